// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encodings, alignment mask, FIFO entry.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries; head is read straight from the storage registers.
// Latency: a push is visible at the head the cycle after the edge. Clear wins over push/pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues word fetches at the current PC, buffers {pc, inst} toward decode.
// Ack in cycle N shows at the head in N+1; requests stop while the FIFO is full.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_pc_step,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);

  state_t       state;
  state_t       state_nxt;
  logic [31:0]  drop_addr;
  logic         latch_drop;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [$clog2(DEPTH):0] count;
  fetch_entry_t head;
  fetch_entry_t wdata;

  always_comb begin
    state_nxt   = state;
    o_imem_req  = 1'b0;
    o_imem_addr = i_pc & WORD_MASK;
    o_pc_step   = 1'b0;
    push        = 1'b0;
    latch_drop  = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        o_imem_req = !full;
        if (!full) begin
          if (i_imem_ack && !i_flush) begin
            push      = 1'b1;
            o_pc_step = 1'b1;
          end else if (i_flush && !i_imem_ack) begin
            latch_drop = 1'b1;
            state_nxt  = DROP;
          end
        end
      end
      DROP: begin
        // The memory still owes us the old fetch; keep it stable and swallow the reply.
        o_imem_req  = 1'b1;
        o_imem_addr = drop_addr;
        if (i_imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drop_addr <= '0;
    end else begin
      state <= state_nxt;
      if (latch_drop) drop_addr <= o_imem_addr;
    end
  end

  assign pop   = o_inst_valid && i_inst_ready && !i_flush;
  assign wdata = '{pc: o_imem_addr, inst: i_imem_rdata};

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (i_flush),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign o_inst_valid = !empty;
  assign o_inst       = head.inst;
  assign o_inst_pc    = head.pc;

endmodule
